servo_pwm_sched: RTL
====================

# servo_pwm_sched

Multi-channel servo PWM scheduler driven by the single-cycle 40 kHz tick from the system clock divider (100 MHz / 2500). Builds a 20 ms (800-tick) servo frame and drives one PWM output per channel. Per-channel pulse widths arrive from the SPI command decoder over a valid/ready handshake. New widths are double-buffered and applied only at frame boundaries, so no output ever produces a glitched pulse.

## Interface
- `NUM_CH`, default 4: number of servo channels, 1..8.
- `FRAME_TICKS`, default 800: ticks per frame (800 × 25 µs = 20 ms).
- `MIN_TICKS`, default 40: minimum non-zero pulse width (1.0 ms).
- `MAX_TICKS`, default 80: maximum pulse width (2.0 ms).
- `clk`, in, 1: 100 MHz system clock.
- `rst`, in, 1: synchronous, active-high reset.
- `tick_in`, in, 1: one-clk-wide pulse from the clock divider, nominally every 2500 clk.
- `cmd_valid`, in, 1: command present.
- `cmd_ready`, out, 1: scheduler accepts the command this cycle.
- `cmd_ch`, in, $clog2(NUM_CH) (min 1): target channel.
- `cmd_width`, in, 8: requested width in ticks; 0 = channel off.
- `pwm_out`, out, NUM_CH: servo pulse outputs, registered.
- `frame_start`, out, 1: one-clk pulse when the frame counter enters 0.

## Operation
- States:
  - IDLE, entered on reset.
  - RUN, entered on the first `tick_in` after reset; stays in RUN until reset.
- Frame counter `frame_cnt`, 10 bits, range 0..FRAME_TICKS-1:
  - IDLE: held at 0.
  - RUN: on each `tick_in`, increments; FRAME_TICKS-1 wraps to 0.
- Load event: the `tick_in` in IDLE, or a `tick_in` in RUN with `frame_cnt == FRAME_TICKS-1`. On a load event:
  - `active[i] <= pending[i]` for all channels.
  - `frame_start <= 1` for one cycle.
- Command accept: on `cmd_valid && cmd_ready`, `pending[cmd_ch] <= clamp(cmd_width)`. A later write to the same channel before the next load event overwrites the earlier one; last write wins.
- `clamp(w)`:
  - w = 0 → 0.
  - 1 ≤ w < MIN_TICKS → MIN_TICKS.
  - w > MAX_TICKS → MAX_TICKS.
  - otherwise w.
- `cmd_ch >= NUM_CH`: the command is accepted and discarded; no state changes.
- `cmd_ready`:
  - 0 during reset, in the cycle `rst` is sampled high, and in any cycle where a load event is sampled.
  - 1 otherwise.
  - This prevents a pending/active race at the frame boundary.
- `pwm_out[i]`: in RUN, the registered value of `(frame_cnt < active[i])`. Always 0 in IDLE.
- A channel with `active[i] == 0` stays low for the whole frame.
- Reset values:
  - `pwm_out` = 0, `frame_start` = 0, `cmd_ready` = 0.
  - `frame_cnt` = 0, all `pending` = 0, all `active` = 0, state = IDLE.
- Reset mid-frame: all outputs drop low at the next edge. Pending commands are lost.
- `tick_in` coinciding with a command: both take effect. The command cannot land in the load cycle because `cmd_ready` is 0 then.

## Timing
- Edge E samples `tick_in` = 1: `frame_cnt` updates at E. `pwm_out` reflects the new count at E+1, i.e. one clk of latency.
- `frame_start` is asserted in the cycle following E, aligned with the `frame_cnt` = 0 state. It precedes the `pwm_out` rise by one clk.
- Pulse high time is exactly `active[i]` ticks (`active[i]` × 2500 clk at nominal tick rate), measured rise to fall.
- Command-to-output latency:
  - Command written before the load tick: applies from that load tick.
  - Worst case: just under one frame (20 ms).
- No throughput limit on commands: one per clk, except in load cycles.

## Configuration
- Macro: `SERVO_SCHED_STAGGER_EN`.
- Defined: channel i uses phase `p_i = (frame_cnt + FRAME_TICKS − i·(FRAME_TICKS/NUM_CH)) mod FRAME_TICKS`.
  - `pwm_out[i] = (p_i < active[i])`.
  - `active[i]` loads on the tick where `p_i` wraps to 0.
  - Rising edges are spread across the frame to limit servo inrush current.
  - `cmd_ready` is 0 in any channel's load cycle.
  - `frame_start` still marks `frame_cnt` = 0.
- Undefined: all channels share phase `frame_cnt` and rise together.

## Test plan
- Reset, then no `tick_in` for 5000 clk → `pwm_out` = 0, `frame_start` = 0, `cmd_ready` = 1 after reset deasserts.
- Write ch0 = 60, then apply ticks every 2500 clk → `frame_start` pulse. `pwm_out[0]` high 60 ticks (150 000 clk), low 740 ticks; period 2 000 000 clk. Other channels stay 0.
- Write ch1 = 10, ch2 = 200, ch3 = 0 → clamped to 40 and 80 ticks; ch3 remains low.
- Write ch0 = 50 at `frame_cnt` = 30 while the ch0 = 60 pulse is running → current pulse still ends at 60. The next frame gives 50.
- Drive `cmd_valid` continuously across the load tick → `cmd_ready` = 0 only in that single cycle. The command is accepted the next clk and applied one frame later.
- Assert `rst` at `frame_cnt` = 20 with `pwm_out[0]` high → `pwm_out` = 0 next edge, state IDLE. Widths are 0 after the restart.
- With `SERVO_SCHED_STAGGER_EN` defined, all channels = 40 → rising edges at `frame_cnt` 0/200/400/600 for ch0..3.

Source files
------------

// File: rtl/servo_pwm_sched_if.sv
// Command channel from the SPI command decoder into the servo scheduler.
// master = command source (decoder), slave = scheduler.
interface servo_pwm_sched_if #(
    parameter int NUM_CH = 4
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic            cmd_valid;
    logic            cmd_ready;
    logic [CH_W-1:0] cmd_ch;
    logic [7:0]      cmd_width;

    modport master (output cmd_valid, output cmd_ch, output cmd_width, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_ch, input cmd_width, output cmd_ready);
endinterface

// File: rtl/servo_pwm_sched.sv
// Multi-channel servo PWM scheduler.
// Builds an 800-tick (20 ms) frame from the 40 kHz tick and drives one PWM
// output per channel. Widths are written into a pending bank over the command
// channel and copied into the active bank only at each channel's load tick,
// so a pulse in progress is never shortened or stretched.
// Optional feature: define SERVO_SCHED_STAGGER_EN to offset channel i by
// i*(FRAME_TICKS/NUM_CH) ticks so rising edges are spread across the frame.
module servo_pwm_sched #(
    parameter int NUM_CH      = 4,
    parameter int FRAME_TICKS = 800,
    parameter int MIN_TICKS   = 40,
    parameter int MAX_TICKS   = 80
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick_in,
    servo_pwm_sched_if.slave    cmd,
    output logic [NUM_CH-1:0]   pwm_out,
    output logic                frame_start
);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = 10;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_TICKS - 1);

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_frame_cnt;
    logic [7:0]       r_pending [NUM_CH];
    logic [7:0]       r_active  [NUM_CH];

    logic [CNT_W-1:0] w_phase [NUM_CH];
    logic [NUM_CH-1:0] w_load;
    logic [NUM_CH-1:0] w_hit;
    logic             w_frame_load;
    logic             w_accept;
    logic [7:0]       w_clamped;

    // Limit a requested width to the servo's legal range; 0 keeps the channel off
    function automatic logic [7:0] clamp(input logic [7:0] w);
        if (w == '0)
            return '0;
        else if (w < 8'(MIN_TICKS))
            return 8'(MIN_TICKS);
        else if (w > 8'(MAX_TICKS))
            return 8'(MAX_TICKS);
        else
            return w;
    endfunction

    // Per-channel phase within the frame
    always_comb begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
`ifdef SERVO_SCHED_STAGGER_EN
            if (r_frame_cnt >= CNT_W'(i * (FRAME_TICKS / NUM_CH)))
                w_phase[i] = r_frame_cnt - CNT_W'(i * (FRAME_TICKS / NUM_CH));
            else
                w_phase[i] = r_frame_cnt + CNT_W'(FRAME_TICKS - i * (FRAME_TICKS / NUM_CH));
`else
            w_phase[i] = r_frame_cnt;
`endif
        end
    end

    // Per-channel load strobe (phase about to wrap) and pulse-active compare
    always_comb begin
        w_load = '0;
        w_hit  = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            w_load[i] = tick_in && ((r_state == ST_IDLE) || (w_phase[i] == LAST));
            w_hit[i]  = (w_phase[i] < {2'b00, r_active[i]});
        end
    end

    assign w_frame_load  = tick_in && ((r_state == ST_IDLE) || (r_frame_cnt == LAST));
    // Refusing commands in any load cycle keeps pending->active copies race-free
    assign cmd.cmd_ready = !rst && !(|w_load);
    assign w_accept      = cmd.cmd_valid && cmd.cmd_ready;
    assign w_clamped     = clamp(cmd.cmd_width);

    // Frame sequencer: IDLE until the first tick, then a free-running frame counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_frame_cnt <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= w_frame_load;
            case (r_state)
                ST_IDLE: begin
                    if (tick_in) begin
                        r_state     <= ST_RUN;
                        r_frame_cnt <= '0;
                    end
                end
                ST_RUN: begin
                    if (tick_in)
                        r_frame_cnt <= (r_frame_cnt == LAST) ? '0 : r_frame_cnt + CNT_W'(1);
                end
            endcase
        end
    end

    // Width double buffer: commands land in pending, load ticks copy to active
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                r_pending[i] <= '0;
                r_active[i]  <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (w_load[i])
                    r_active[i] <= r_pending[i];
                // Out-of-range channel numbers match no entry and are dropped
                if (w_accept && (cmd.cmd_ch == CH_W'(i)))
                    r_pending[i] <= w_clamped;
            end
        end
    end

    // Registered PWM outputs, forced low outside RUN
    always_ff @(posedge clk) begin
        if (rst)
            pwm_out <= '0;
        else
            pwm_out <= (r_state == ST_RUN) ? w_hit : '0;
    end
endmodule
